// File: rtl/modbus_pkg.sv
// Shared types and constants for the Modbus RTU receive path.
package modbus_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_RECV,
    ST_GAP,
    ST_CHECK,
    ST_HOLD,
    ST_DISCARD
  } state_t;

  localparam logic [2:0] ERR_OVF   = 3'd1;
  localparam logic [2:0] ERR_GAP   = 3'd2;
  localparam logic [2:0] ERR_SHORT = 3'd3;
  localparam logic [2:0] ERR_CRC   = 3'd4;

  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam logic [15:0] CRC_POLY = 16'hA001;

  // Above 19200 baud the silent intervals are fixed at 750 us / 1750 us.
  function automatic int unsigned calc_sil_cyc(input longint unsigned clk_freq,
                                               input longint unsigned baud,
                                               input bit              is_t35);
    longint unsigned r;
    longint unsigned mul;
    if (baud > 64'd19200) begin
      mul = is_t35 ? 64'd1750 : 64'd750;
      r   = (clk_freq * mul) / 64'd1000000;
    end else begin
      mul = is_t35 ? 64'd77 : 64'd33;
      r   = (clk_freq * mul) / (64'd2 * baud);
    end
    return r[31:0];
  endfunction

endpackage

// File: rtl/modbus_rx_frame_ctrl_crc.sv
// Bit-serial CRC-16/Modbus engine: one byte folded in over 8 clock cycles.
module crc16_modbus_serial
  import modbus_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        init,
  input  logic        start,
  input  logic [7:0]  data,
  output logic        busy,
  output logic [15:0] crc
);

  logic [15:0] r_crc;
  logic [2:0]  r_bits;
  logic        r_busy;
  logic [15:0] w_base;
  logic [15:0] w_shift_in;
  logic [15:0] w_next;

  function automatic logic [15:0] crc_step(input logic [15:0] c);
    return c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
  endfunction

  // The data XOR is merged with the first shift so a byte costs exactly 8 cycles.
  always_comb begin
    w_base     = init ? CRC_INIT : r_crc;
    w_shift_in = start ? (w_base ^ {8'h00, data}) : w_base;
    w_next     = crc_step(w_shift_in);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_crc  <= CRC_INIT;
      r_bits <= '0;
      r_busy <= 1'b0;
    end else if (start) begin
      r_crc  <= w_next;
      r_bits <= 3'd7;
      r_busy <= 1'b1;
    end else if (init) begin
      r_crc  <= CRC_INIT;
      r_bits <= '0;
      r_busy <= 1'b0;
    end else if (r_busy) begin
      r_crc  <= w_next;
      r_bits <= r_bits - 3'd1;
      if (r_bits == 3'd1) r_busy <= 1'b0;
    end
  end

  assign busy = r_busy;
  assign crc  = r_crc;

endmodule

// File: rtl/modbus_rx_frame_ctrl.sv
// Modbus RTU frame receive sequencer: silent-interval framing, buffer writes,
// length/CRC/address checks and done/ack hand-off to the command decoder.
module modbus_rx_frame_ctrl
  import modbus_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned BAUD_RATE = 9600,
  parameter int unsigned MAX_LEN   = 256
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  input  logic       rx_state,
  input  logic [7:0] slave_addr,
  output logic       buf_we,
  output logic [7:0] buf_waddr,
  output logic [7:0] buf_wdata,
  output logic       frame_done,
  output logic [8:0] frame_len,
  output logic       frame_bcast,
  input  logic       frame_ack,
  output logic       frame_err,
  output logic [2:0] err_code
);

  localparam logic [23:0] T15_CYC =
    24'(calc_sil_cyc(64'(CLK_FREQ), 64'(BAUD_RATE), 1'b0));
  localparam logic [23:0] T35_CYC =
    24'(calc_sil_cyc(64'(CLK_FREQ), 64'(BAUD_RATE), 1'b1));
  localparam logic [8:0] MAX_LEN_W = 9'(MAX_LEN);

  state_t      r_state;
  logic [23:0] r_cnt;
  logic [8:0]  r_len;
  logic [7:0]  r_byte0;
  logic        r_we;
  logic [7:0]  r_waddr;
  logic [7:0]  r_wdata;
  logic        r_crc_init;
  logic        r_done;
  logic        r_err;
  logic [2:0]  r_err_code;
  logic [8:0]  r_frame_len;
  logic        r_bcast;

  logic        w_sil15;
  logic        w_sil35;
  logic        w_crc_busy;
  logic [15:0] w_crc;

  // The CRC engine is fed from the registered write strobe, so it sees each
  // byte on the same cycle the buffer does.
  crc16_modbus_serial u_crc (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .init     (r_crc_init),
    .start    (r_we),
    .data     (r_wdata),
    .busy     (w_crc_busy),
    .crc      (w_crc)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_cnt <= '0;
    end else if (rx_done || rx_state) begin
      r_cnt <= '0;
    end else if (r_cnt < T35_CYC) begin
      r_cnt <= r_cnt + 24'd1;
    end
  end

  assign w_sil15 = (r_cnt >= T15_CYC);
  assign w_sil35 = (r_cnt >= T35_CYC);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state     <= ST_INIT;
      r_len       <= '0;
      r_byte0     <= '0;
      r_we        <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_crc_init  <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_err_code  <= '0;
      r_frame_len <= '0;
      r_bcast     <= 1'b0;
    end else begin
      r_we       <= 1'b0;
      r_crc_init <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      case (r_state)
        ST_INIT: begin
          if (!rx_done && w_sil35) r_state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (rx_done) begin
            r_we       <= 1'b1;
            r_waddr    <= '0;
            r_wdata    <= rx_data;
            r_len      <= 9'd1;
            r_byte0    <= rx_data;
            r_crc_init <= 1'b1;
            r_state    <= ST_RECV;
          end
        end
        ST_RECV: begin
          if (rx_done) begin
            if (r_len == MAX_LEN_W) begin
              r_err      <= 1'b1;
              r_err_code <= ERR_OVF;
              r_state    <= ST_DISCARD;
            end else begin
              r_we    <= 1'b1;
              r_waddr <= r_len[7:0];
              r_wdata <= rx_data;
              r_len   <= r_len + 9'd1;
            end
          end else if (w_sil15) begin
            r_state <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (rx_done) begin
            r_err      <= 1'b1;
            r_err_code <= ERR_GAP;
            r_state    <= ST_DISCARD;
          end else if (w_sil35) begin
            r_state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (!w_crc_busy && !r_we) begin
            if (r_len < 9'd4) begin
              r_err      <= 1'b1;
              r_err_code <= ERR_SHORT;
              r_state    <= ST_IDLE;
            end else if (w_crc != 16'h0000) begin
              r_err      <= 1'b1;
              r_err_code <= ERR_CRC;
              r_state    <= ST_IDLE;
            end else if ((r_byte0 != slave_addr) && (r_byte0 != 8'h00)) begin
              r_state <= ST_IDLE;
            end else begin
              r_done      <= 1'b1;
              r_frame_len <= r_len;
              r_bcast     <= (r_byte0 == 8'h00);
              r_state     <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (frame_ack) r_state <= ST_INIT;
        end
        ST_DISCARD: begin
          if (!rx_done && w_sil35) r_state <= ST_IDLE;
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

  assign buf_we      = r_we;
  assign buf_waddr   = r_waddr;
  assign buf_wdata   = r_wdata;
  assign frame_done  = r_done;
  assign frame_len   = r_frame_len;
  assign frame_bcast = r_bcast;
  assign frame_err   = r_err;
  assign err_code    = r_err_code;

endmodule

// File: doc/modbus_rx_frame_ctrl.md
Name: modbus_rx_frame_ctrl

Overview:
- Frame-level receive sequencer for the Modbus RTU slave.
- Sits between the UART byte receiver (rx_done / rx_data / rx_state) and the request frame buffer.
- Delimits RTU frames using 1.5-char and 3.5-char silent-interval timing, writes bytes into the buffer, and checks length, CRC-16 and slave address.
- Hands each valid frame to the command decoder with a done/ack handshake.

Parameters:
- CLK_FREQ, 50000000: system clock frequency in Hz.
- BAUD_RATE, 9600: line baud rate.
- MAX_LEN, 256: maximum frame length in bytes, address through CRC inclusive.
- T15_CYC (derived constant): if BAUD_RATE>19200, CLK_FREQ*750/1e6; else CLK_FREQ*33/(2*BAUD_RATE). Default 85937.
- T35_CYC (derived constant): if BAUD_RATE>19200, CLK_FREQ*1750/1e6; else CLK_FREQ*77/(2*BAUD_RATE). Default 200520.

Ports:
- clk_in  in  1  system clock
- rst_n_in  in  1  asynchronous active-low reset
- rx_done  in  1  one-cycle pulse; rx_data is valid
- rx_data  in  8  received byte
- rx_state  in  1  high while the UART is mid-character
- slave_addr  in  8  this node's address (1..247), quasi-static
- buf_we  out  1  frame buffer write strobe
- buf_waddr  out  8  frame buffer write address
- buf_wdata  out  8  frame buffer write data
- frame_done  out  1  one-cycle pulse; valid frame is in the buffer
- frame_len  out  9  byte count of the last frame, CRC included
- frame_bcast  out  1  last valid frame had address 0
- frame_ack  in  1  consumer releases the buffer
- frame_err  out  1  one-cycle error pulse
- err_code  out  3  1=overflow, 2=t1.5 gap violation, 3=short (<4 bytes), 4=CRC fail; held until next error

Behaviour:
- Reset (clk_in, rst_n_in as stated above): all outputs 0, state INIT, silence counter 0, CRC register 0xFFFF.
- Silence counter (24 bit):
  - cleared on rx_done; held at 0 while rx_state=1; otherwise increments, saturating at T35_CYC.
  - sil15 = (cnt>=T15_CYC); sil35 = (cnt>=T35_CYC).
- Byte write: buf_we pulses exactly 1 cycle after an accepted rx_done; buf_wdata = that byte; buf_waddr = current len; then len increments.
- CRC: bit-serial CRC-16/Modbus (init 0xFFFF, reflected poly 0xA001).
  - Started by every accepted byte; 8 cycles per byte.
  - Bytes are spaced far more than 8 cycles apart, so no queuing is required.
  - A frame is valid when the final residue over all bytes, CRC included, equals 0x0000.
- INIT: wait for sil35 -> IDLE. Any rx_done in INIT is ignored.
- IDLE: rx_done -> accept the byte at address 0, set len=1, reset CRC to 0xFFFF, latch byte0 -> RECV.
- RECV:
  - rx_done with len==MAX_LEN -> DISCARD, err_code=1.
  - rx_done otherwise -> accept the byte.
  - sil15 -> GAP.
- GAP:
  - rx_done -> DISCARD, err_code=2 (byte not written).
  - sil35 -> CHECK.
- CHECK: wait for the CRC engine to be idle, then evaluate in priority order:
  - len<4 -> frame_err, code 3, -> IDLE.
  - residue!=0 -> frame_err, code 4, -> IDLE.
  - byte0!=slave_addr and byte0!=0 -> silently -> IDLE (no pulse).
  - else frame_done pulse; frame_len=len; frame_bcast=(byte0==0); -> HOLD.
- HOLD:
  - Buffer is frozen: buf_we never asserts and incoming bytes are dropped.
  - frame_ack -> INIT, so any partially-seen frame is skipped.
  - frame_ack is ignored in every other state.
- DISCARD:
  - frame_err pulses on the entry cycle with err_code set.
  - Further bytes are dropped; sil35 -> IDLE.
- Simultaneous rx_done and sil15/sil35 in the same cycle: rx_done wins, because the counter is cleared.
- frame_len and frame_bcast hold their values until the next frame_done.
- Reset mid-frame: immediate return to INIT; any partial buffer contents are don't-care.

Decomposition:
- Package modbus_pkg:
  - state enum (INIT, IDLE, RECV, GAP, CHECK, HOLD, DISCARD).
  - err_code constants ERR_OVF, ERR_GAP, ERR_SHORT, ERR_CRC.
  - function computing T15_CYC/T35_CYC from CLK_FREQ and BAUD_RATE.
  - CRC_INIT=16'hFFFF, CRC_POLY=16'hA001.
- Sub-module crc16_modbus_serial:
  - inputs: clk_in, rst_n_in, init, start, data[7:0].
  - outputs: busy, crc[15:0].
  - 8-cycle bit-serial engine.
- The controller holds the FSM, silence counter, length counter and buffer write logic.

Test Plan:
- Benches run with CLK_FREQ=1000000, BAUD_RATE=9600, giving T15=1718 and T35=4010 cycles.
- Bytes 01 03 00 00 00 01 84 0A, slave_addr=1, after 4010 idle cycles -> 8 buf_we writes at addresses 0..7; frame_done 4010 cycles after the last byte; frame_len=8; frame_bcast=0; no frame_err.
- Same frame with the last byte 0B -> frame_err, err_code=4; no frame_done; state returns to IDLE.
- Same frame with a 2500-cycle gap after byte 3 -> frame_err, err_code=2, at the 4th byte; the next valid frame, sent after 4010 silent cycles, completes normally.
- Frame with address 05, slave_addr=1 -> no frame_done, no frame_err. Frame with address 00 -> frame_done with frame_bcast=1.
- 257 bytes back-to-back -> frame_err, err_code=1, at byte 257, which is not written. 3-byte frame -> err_code=3.
- Second frame arrives while in HOLD -> no buf_we. After frame_ack, the first complete frame after 4010 silent cycles is accepted. Reset asserted mid-frame -> all outputs 0 and 4010-cycle resync before the next frame is accepted.
